// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter_if
//  Purpose  : Bundles the display-scan, pixel-RAM, writer and page-swap
//             signals of the VGA frame-buffer arbiter. The arbiter uses
//             the slave view; its environment uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_fb_arbiter_if #(
    parameter int PAGE_W = 15
);
    // display scan from the VGA driver
    logic              disp_active;
    logic [10:0]       disp_x;
    logic [10:0]       disp_y;
    logic              vs_in;
    logic [23:0]       rgb;
    // single-port pixel RAM
    logic [PAGE_W:0]   mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    // drawing / acquisition writer
    logic              wr_req;
    logic [PAGE_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ack;
    logic              wr_err;
    // page swap
    logic              swap_req;
    logic              swap_pend;
    logic              swap_done;
    logic              front_page;

    modport master (
        output disp_active, disp_x, disp_y, vs_in, mem_rdata,
               wr_req, wr_addr, wr_data, swap_req,
        input  rgb, mem_addr, mem_we, mem_wdata, wr_ack, wr_err,
               swap_pend, swap_done, front_page
    );

    modport slave (
        input  disp_active, disp_x, disp_y, vs_in, mem_rdata,
               wr_req, wr_addr, wr_data, swap_req,
        output rgb, mem_addr, mem_we, mem_wdata, wr_ack, wr_err,
               swap_pend, swap_done, front_page
    );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter
//  Purpose  : Shares one single-port RGB332 pixel RAM (two pages of 4x4
//             pixel blocks) between the VGA display scan and a writer.
//             Display reads always win; the writer uses the free cycles.
//             Page swaps are deferred to the next vertical sync.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int H_BLK  = 200,
    parameter int V_BLK  = 150,
    parameter int PAGE_W = 15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    vga_fb_arbiter_if.slave    fb
);

    localparam logic [PAGE_W-1:0] c_NBLK     = PAGE_W'(H_BLK * V_BLK);
    localparam logic [0:0]        c_ST_SHOWN = 1'b0;
    localparam logic [0:0]        c_ST_PEND  = 1'b1;

    // display pipeline and write-handshake registers
    logic [PAGE_W:0]   mem_addr_q;
    logic              rd_issued_q;
    logic              act1_q;
    logic              act2_q;
    logic [7:0]        pix_q;
    logic              wr_ack_q;
    logic              wr_err_q;

    // swap state machine registers
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              vs_q;
    logic              front_q;
    logic              front_d;
    logic              swap_done_q;
    logic              swap_done_d;

    // combinational helpers
    logic [PAGE_W-1:0] w_by;
    logic [PAGE_W-1:0] w_bx;
    logic [PAGE_W-1:0] w_rd_idx;
    logic              w_slot;
    logic              w_grant;
    logic              w_oor;
    logic              w_vs_fall;
    logic              w_pend;
    logic [PAGE_W:0]   mem_addr_d;
    logic              w_mem_we;
    logic [7:0]        w_mem_wdata;

    // Block index of the current pixel; y*200 is 128y + 64y + 8y (fixed to H_BLK = 200).
    always_comb begin
        w_by     = PAGE_W'(fb.disp_y[10:2]);
        w_bx     = PAGE_W'(fb.disp_x[10:2]);
        w_rd_idx = (w_by << 7) + (w_by << 6) + (w_by << 3) + w_bx;
    end

    // Slot and grant decode; gated by rst_n so nothing reaches the RAM while in reset.
    always_comb begin
        w_slot    = rst_n & fb.disp_active & (fb.disp_x[1:0] == 2'b00);
        w_grant   = rst_n & fb.wr_req & ~w_slot & ~wr_ack_q;
        w_oor     = (fb.wr_addr >= c_NBLK);
        w_vs_fall = vs_q & ~fb.vs_in;
    end

    // RAM port mux: display read first, then writer, otherwise hold the address.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        w_mem_we    = 1'b0;
        w_mem_wdata = 8'h00;
        if (w_slot) begin
            mem_addr_d = {front_q, w_rd_idx};
        end else if (w_grant) begin
            mem_addr_d  = {~front_q, fb.wr_addr};
            w_mem_we    = ~w_oor;
            w_mem_wdata = fb.wr_data;
        end
    end

    // Display pipeline, pixel latch and write acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            rd_issued_q <= 1'b0;
            act1_q      <= 1'b0;
            act2_q      <= 1'b0;
            pix_q       <= 8'h00;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            rd_issued_q <= w_slot;
            act1_q      <= fb.disp_active;
            act2_q      <= act1_q;
            if (rd_issued_q) begin
                pix_q <= fb.mem_rdata;
            end
            wr_ack_q    <= w_grant;
            wr_err_q    <= w_grant & w_oor;
        end
    end

    // Swap FSM state register, vsync history, displayed page and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_SHOWN;
            vs_q        <= 1'b0;
            front_q     <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= fb.vs_in;
            front_q     <= front_d;
            swap_done_q <= swap_done_d;
        end
    end

    // Swap FSM next state: a request arms it, the vsync falling edge fires it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_SHOWN: if (fb.swap_req) state_d = c_ST_PEND;
            c_ST_PEND:  if (w_vs_fall)   state_d = c_ST_SHOWN;
            default:    state_d = c_ST_SHOWN;
        endcase
    end

    // Swap FSM outputs: toggle the page and pulse done when a pending swap fires.
    always_comb begin
        w_pend      = (state_q == c_ST_PEND);
        swap_done_d = w_pend & w_vs_fall;
        front_d     = front_q ^ swap_done_d;
    end

    // RGB332 expansion by bit replication, blanked outside the delayed active area.
    always_comb begin
        if (act2_q) begin
            fb.rgb = {pix_q[7:5], pix_q[7:5], pix_q[7:6],
                      pix_q[4:2], pix_q[4:2], pix_q[4:3],
                      pix_q[1:0], pix_q[1:0], pix_q[1:0], pix_q[1:0]};
        end else begin
            fb.rgb = 24'h000000;
        end
    end

    assign fb.mem_addr   = mem_addr_d;
    assign fb.mem_we     = w_mem_we;
    assign fb.mem_wdata  = w_mem_wdata;
    assign fb.wr_ack     = wr_ack_q;
    assign fb.wr_err     = wr_err_q;
    assign fb.swap_pend  = w_pend;
    assign fb.swap_done  = swap_done_q;
    assign fb.front_page = front_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_arbiter
//  Purpose  : Self-checking bench for vga_fb_arbiter: directed scans, random
//             writes and page swaps against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.PAGE_W(15)) fb();

    vga_fb_arbiter #(.H_BLK(200), .V_BLK(150), .PAGE_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (fb)
    );

    // Pixel RAM: synchronous read, data one clock after the address.
    logic [7:0] ram  [0:65535];
    logic [7:0] refm [0:65535];

    always @(posedge clk) begin
        if (fb.mem_we) ram[fb.mem_addr] <= fb.mem_wdata;
        fb.mem_rdata <= ram[fb.mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [14:0] a; logic [7:0] d; } txn_t;
    txn_t wq[$];

    // reference model state
    logic        m_front, m_pend, m_done, m_prev_vs;
    logic [23:0] e1, e2;
    logic        busy, cur_oor, cur_page;
    logic [14:0] cur_a;
    logic [7:0]  cur_d;
    int          we_cnt, wait_cnt;
    logic        vs_lvl;
    logic [23:0] cap [0:11];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] c);
        logic [2:0] r, g;
        logic [1:0] b;
        r = c[7:5];
        g = c[4:2];
        b = c[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    function automatic logic [14:0] blk_idx(input int x, input int y);
        return 15'((y / 4) * 200 + (x / 4));
    endfunction

    task automatic model_reset();
        m_front = 0; m_pend = 0; m_done = 0; m_prev_vs = 0;
        e1 = 0; e2 = 0; busy = 0; we_cnt = 0; wait_cnt = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check RAM port, advance model.
    task automatic step(input logic act, input int x, input int y, input logic vs,
                        input logic sreq, input logic rst_mid);
        logic        slot, fall;
        logic [14:0] ix;
        @(negedge clk);
        check("rgb", fb.rgb, e2);
        check("swap_pend", fb.swap_pend, m_pend);
        check("front_page", fb.front_page, m_front);
        check("swap_done", fb.swap_done, m_done);
        if (busy && fb.wr_ack) begin
            check("wr_err", fb.wr_err, cur_oor);
            check("we_count", we_cnt, cur_oor ? 0 : 1);
            if (!cur_oor) refm[{cur_page, cur_a}] = cur_d;
            busy = 0;
        end else begin
            check("wr_ack_idle", fb.wr_ack, 0);
            check("wr_err_idle", fb.wr_err, 0);
            if (busy) begin
                wait_cnt++;
                if (wait_cnt > 2) begin
                    check("wr_ack_wait", wait_cnt, 2);
                    busy = 0;
                end
            end
        end
        if (!busy && rst_n && wq.size() > 0) begin
            txn_t t;
            t = wq.pop_front();
            cur_a = t.a; cur_d = t.d; cur_oor = (int'(t.a) >= 30000);
            busy = 1; we_cnt = 0; wait_cnt = 0;
        end
        fb.disp_active = act;
        fb.disp_x      = 11'(x);
        fb.disp_y      = 11'(y);
        fb.vs_in       = vs;
        fb.swap_req    = sreq;
        fb.wr_req      = busy;
        fb.wr_addr     = cur_a;
        fb.wr_data     = cur_d;
        #1;
        slot = act && (x % 4 == 0) && rst_n;
        ix   = blk_idx(x, y);
        if (slot) begin
            check("rd_addr", fb.mem_addr, {m_front, ix});
            check("rd_we", fb.mem_we, 0);
        end else begin
            check("spurious_we", fb.mem_we & ~busy, 0);
            if (fb.mem_we && busy) begin
                check("wr_addr", fb.mem_addr, {~m_front, cur_a});
                check("wr_data", fb.mem_wdata, cur_d);
                we_cnt++;
                cur_page = ~m_front;
            end
        end
        e2 = e1;
        e1 = (act && rst_n) ? expand(refm[{m_front, ix}]) : 24'h0;
        if (rst_mid) begin
            check("rst_grant_we", fb.mem_we, 1);
            rst_n = 0;
            #1;
            model_reset();
        end else if (rst_n) begin
            fall   = m_prev_vs && !vs;
            m_done = 0;
            if (!m_pend) begin
                if (sreq) m_pend = 1;
            end else if (fall) begin
                m_front = ~m_front;
                m_pend  = 0;
                m_done  = 1;
            end
            m_prev_vs = vs;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, vs_lvl, 0, 0);
    endtask

    task automatic scan_line(input int y, input int sreq_x);
        for (int x = 0; x < 800; x++) step(1, x, y, vs_lvl, x == sreq_x, 0);
        idle(8);
    endtask

    task automatic check_reset_outputs();
        check("rst_rgb", fb.rgb, 0);
        check("rst_mem_addr", fb.mem_addr, 0);
        check("rst_mem_we", fb.mem_we, 0);
        check("rst_mem_wdata", fb.mem_wdata, 0);
        check("rst_wr_ack", fb.wr_ack, 0);
        check("rst_wr_err", fb.wr_err, 0);
        check("rst_swap_pend", fb.swap_pend, 0);
        check("rst_swap_done", fb.swap_done, 0);
        check("rst_front", fb.front_page, 0);
    endtask

    initial begin
        fb.disp_active = 0; fb.disp_x = 0; fb.disp_y = 0; fb.vs_in = 0;
        fb.wr_req = 0; fb.wr_addr = 0; fb.wr_data = 0; fb.swap_req = 0;
        cur_a = 0; cur_d = 0; cur_oor = 0; cur_page = 0;
        vs_lvl = 0;
        model_reset();
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = 8'($urandom);
            refm[i] = ram[i];
        end
        ram[0] = 8'hE0; refm[0] = 8'hE0;
        ram[1] = 8'h1C; refm[1] = 8'h1C;

        // reset state
        idle(3);
        check_reset_outputs();
        rst_n  = 1;
        vs_lvl = 1;
        idle(4);

        // line 0 scan with a held write to block 5 of the back page
        wq.push_back('{15'd5, 8'h03});
        for (int x = 0; x < 12; x++) begin
            step(1, x, 0, vs_lvl, 0, 0);
            cap[x] = fb.rgb;
        end
        idle(4);
        for (int k = 2; k < 6; k++)  check("line0_red",   cap[k], 24'hFF0000);
        for (int k = 6; k < 10; k++) check("line0_green", cap[k], 24'h00FF00);

        // out-of-range write
        wq.push_back('{15'd30000, 8'h55});
        idle(4);

        // random writes during full-line scans, including the bottom-right corner
        for (int i = 0; i < 40; i++) begin
            logic [14:0] a;
            a = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(30000, 32767))
                                            : 15'($urandom_range(0, 29999));
            wq.push_back('{a, 8'($urandom)});
        end
        scan_line(599, -1);
        for (int l = 0; l < 3; l++) scan_line($urandom_range(0, 598), -1);

        // two swap requests mid-frame, one vsync fall
        scan_line($urandom_range(0, 599), 100);
        scan_line($urandom_range(0, 599), 300);
        vs_lvl = 0; idle(4);
        vs_lvl = 1; idle(4);
        wq.push_back('{15'd7, 8'hA5});
        idle(4);
        scan_line(0, -1);
        scan_line(599, -1);
        for (int i = 0; i < 20; i++) wq.push_back('{15'($urandom_range(0, 29999)), 8'($urandom)});
        scan_line($urandom_range(0, 599), -1);

        // swap request coinciding with the vsync fall only arms the swap
        step(0, 0, 0, 0, 1, 0);
        vs_lvl = 0; idle(3);
        vs_lvl = 1; idle(3);
        vs_lvl = 0; idle(3);
        vs_lvl = 1; idle(3);
        scan_line($urandom_range(0, 599), -1);

        // reset with a swap pending and a granted write not yet acknowledged
        step(0, 0, 0, 1, 1, 0);
        wq.push_back('{15'd9, 8'h11});
        step(0, 0, 0, 1, 0, 1);
        idle(3);
        check_reset_outputs();
        rst_n = 1;
        idle(3);
        vs_lvl = 0; idle(4);
        vs_lvl = 1; idle(4);
        scan_line(0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
